// File: rtl/sat_enum_driver.sv
// Exhaustive input enumerator for a circuit-SAT CUT; reports the first hit or exhaustion.
// Optional feature macro SAT_ENUM_COUNT_ALL_EN: keep searching and count every hit.
module sat_enum_driver #(
  parameter int N_IN = 8,
  parameter int PIPE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            abort_i,
  output logic [N_IN-1:0] cand_o,
  input  logic            sat_in_i,
  output logic            busy_o,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic            res_found_o,
  output logic [N_IN-1:0] res_vec_o,
  output logic [N_IN:0]   res_count_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [N_IN:0] LAST    = (N_IN+1)'((1 << N_IN) - 1);
  localparam logic [N_IN:0] CNT_MAX = (N_IN+1)'(1 << N_IN);
  localparam logic [N_IN:0] ONE     = (N_IN+1)'(1);

`ifdef SAT_ENUM_COUNT_ALL_EN
  localparam bit STOP_ON_HIT = 1'b0;
`else
  localparam bit STOP_ON_HIT = 1'b1;
`endif

  state_t          state_q;
  logic [N_IN:0]   cnt_q;
  logic            busy_q;
  logic            valid_q;
  logic            found_q;
  logic [N_IN-1:0] vec_q;

  logic            tail_v;
  logic [N_IN-1:0] tail_vec;
  logic            drain_empty;
  logic            hit;
  logic            last_issue;

  assign hit        = tail_v && sat_in_i && ((state_q == RUN) || (state_q == DRAIN));
  assign last_issue = (cnt_q == LAST);

  generate
    if (PIPE == 0) begin : g_nopipe
      // Combinational CUT: the vector on cand_o is the one being judged.
      assign tail_v      = (state_q == RUN);
      assign tail_vec    = cnt_q[N_IN-1:0];
      assign drain_empty = 1'b1;
    end else begin : g_pipe
      logic            issue;
      logic            pipe_clr;
      logic [PIPE-1:0] tag_v_q;
      logic [PIPE-1:0] tag_v_sh;
      logic [N_IN-1:0] tag_vec_q [PIPE];

      assign issue    = (state_q == RUN);
      assign pipe_clr = abort_i || (state_q == IDLE) || (state_q == DONE) ||
                        (hit && STOP_ON_HIT);
      assign tag_v_sh = tag_v_q << 1;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_v_q <= '0;
        end else if (pipe_clr) begin
          tag_v_q <= '0;
        end else begin
          tag_v_q <= tag_v_sh | PIPE'(issue);
        end
      end

      // NOTE: the vector payload carries no reset; its valid bit alone decides whether it is read.
      always_ff @(posedge clk) begin
        tag_vec_q[0] <= cnt_q[N_IN-1:0];
        for (int i = 1; i < PIPE; i++) begin
          tag_vec_q[i] <= tag_vec_q[i-1];
        end
      end

      assign tail_v      = tag_v_q[PIPE-1];
      assign tail_vec    = tag_vec_q[PIPE-1];
      // DRAIN pushes nothing, so the pipe is empty once the tail leaves.
      assign drain_empty = (tag_v_sh == '0);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      found_q <= 1'b0;
      vec_q   <= '0;
    end else if (abort_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            found_q <= 1'b0;
            vec_q   <= '0;
          end
        end
        RUN, DRAIN: begin
          if (hit) begin
            found_q <= 1'b1;
            vec_q   <= tail_vec;
          end
          if (hit && STOP_ON_HIT) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end else if (state_q == RUN) begin
            if (!last_issue) begin
              cnt_q <= cnt_q + ONE;
            end else if (PIPE == 0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end else if (drain_empty) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef SAT_ENUM_COUNT_ALL_EN
  logic [N_IN:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (abort_i) begin
      count_q <= count_q;
    end else if ((state_q == IDLE) && start_i) begin
      count_q <= '0;
    end else if (hit && (count_q != CNT_MAX)) begin
      count_q <= count_q + ONE;
    end
  end

  assign res_count_o = count_q;
`else
  assign res_count_o = {{N_IN{1'b0}}, found_q};
`endif

  assign cand_o      = cnt_q[N_IN-1:0];
  assign busy_o      = busy_q;
  assign res_valid_o = valid_q;
  assign res_found_o = found_q;
  assign res_vec_o   = vec_q;

endmodule

// File: doc/sat_enum_driver.md
# sat_enum_driver

Sequential exhaustive-search engine that drives the primary inputs of a combinational circuit-SAT benchmark (e.g. the multiplier-factorization cones, packed as {a, b}) and consumes its single `sat` output. It enumerates every input vector from 0 to 2^N_IN−1, one vector per clock. It tracks in-flight vectors through an optional pipeline on the `sat` path, and reports the first satisfying assignment, or exhaustion, through a valid/ready result port. It is the baseline brute-force reference against which the solver's answers are checked.

## Interface
- N_IN, 8, candidate vector width (benchmark input count); 1..16
- PIPE, 0, cycles between `cand` change and the matching `sat_in`; 0..7 (0 = purely combinational CUT)
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a search; sampled only in IDLE
- abort  input  1  cancel; returns to IDLE from any state
- cand  output  N_IN  candidate vector to CUT inputs (registered)
- sat_in  input  1  CUT output for the vector issued PIPE cycles earlier
- busy  output  1  high in RUN and DRAIN
- res_valid  output  1  result available
- res_ready  input  1  result consumed
- res_found  output  1  at least one satisfying vector seen
- res_vec  output  N_IN  satisfying vector (first hit, or last hit with the count-all feature)
- res_count  output  N_IN+1  number of hits recorded (0 or 1 without the count-all feature)

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: `cand`=0. On `start`=1, clear the counter, the hit count and the tag pipe, then go to RUN.
- RUN: `cand` = counter value. A valid tag is pushed into a PIPE-deep tag pipe; with PIPE=0 there is no pipe and the current `cand` is checked directly. The counter is N_IN+1 bits wide. After issuing 2^N_IN−1 the block goes to DRAIN. It never wraps to re-issue 0.
- Hit: the tag at the pipe tail is valid, the tail vector is recorded, and `sat_in`=1. `sat_in` is ignored when the tail tag is invalid.
- First hit, without the feature: latch `res_vec` = tail vector, set `res_found`=1 and `res_count`=1, go to DONE, discard in-flight tags.
- DRAIN: issue nothing and keep `cand` at its last value. Evaluate remaining tags. Go to DONE when the pipe is empty, which is immediate for PIPE=0.
- DONE: `res_valid`=1, and the result outputs are stable until the cycle `res_valid && res_ready` holds. That cycle returns the block to IDLE. `start` is ignored in DONE.
- `abort`=1 has priority over everything: next state IDLE, `res_valid`=0, tag pipe cleared, any pending result dropped.
- `start` is ignored outside IDLE.
- Simultaneous hit and last issue: the hit takes priority and the block goes to DONE.

## Timing
- Reset values: `cand`=0, `busy`=0, `res_valid`=0, `res_found`=0, `res_vec`=0, `res_count`=0, state IDLE.
- Define edge k as the edge where `start` is sampled in IDLE. Vector v is driven on `cand` during cycle k+1+v.
- The hit on v is sampled at edge k+1+v+PIPE. `res_valid` rises in the following cycle.
- Worst-case latency from `start` to `res_valid`: 2^N_IN + PIPE + 1 cycles.
- `busy` rises the cycle after `start` and falls when DONE is entered.
- `res_valid`, once high, stays high without `res_ready`, except when `abort` is asserted.

## Configuration
- Macro: SAT_ENUM_COUNT_ALL_EN.
- Defined: a hit does not terminate RUN. Each hit increments `res_count` (saturating at 2^N_IN) and overwrites `res_vec`. DONE is entered only after DRAIN empties. `res_found` = (`res_count` != 0).
- Undefined: first-hit termination as described in Operation. `res_count` is tied to {N_IN'b0, res_found}.

## Test plan
- PIPE=0; the bench CUT asserts sat only for `cand`==8'hA5; pulse `start` -> `res_valid` rises 0xA5+2 cycles after the start edge, with `res_found`=1, `res_vec`=8'hA5, `res_count`=1.
- PIPE=0; sat never asserted -> `res_valid` rises 257 cycles after start, with `res_found`=0, `res_count`=0. `cand` holds 8'hFF during DRAIN/DONE.
- PIPE=3; the CUT is delayed 3 cycles and sat holds only for 8'h00 -> `res_vec`=8'h00, `res_valid` 5 cycles after start. Stale `sat_in` before the first tag is ignored.
- `abort` asserted at `cand`==8'h40 during RUN -> next cycle IDLE, `busy`=0, `res_valid`=0. A following `start` restarts from 8'h00.
- Hit found, `res_ready` held low for 10 cycles -> `res_valid` and `res_vec` stable. `start` pulses are ignored. Raising `res_ready` for one cycle returns the block to IDLE.
- SAT_ENUM_COUNT_ALL_EN defined; sat = `cand`[0] -> `res_count`=128, `res_vec`=8'hFF, `res_found`=1, `res_valid` at 257+PIPE cycles.
